ws2812_stream_driver: RTL and testbench

WS2812_STREAM_DRIVER -- requirements
Module: ws2812_stream_driver

---
 rtl/ws2812_pkg.sv | 21 ++
 rtl/ws_timer.sv | 27 ++
 rtl/ws2812_stream_driver.sv | 168 ++++++++++++++++
 tb/tb_ws2812_stream_driver.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 serial pixel driver.
// Pixels are 24-bit GRB words shifted out MSB first.
package ws2812_pkg;

    localparam int PIXEL_BITS    = 24;
    // GRB order: G7 is the first bit on the wire, B0 the last.
    localparam int GRB_FIRST_BIT = PIXEL_BITS - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HIGH,
        ST_LOW,
        ST_LATCH
    } ws_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws_timer.sv
// Loadable down-counter used for every timed phase of the WS2812 waveform.
// A phase of N cycles loads N-1; expired is high in the phase's final cycle.
module ws_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] load_val,
    input  logic         load,
    output logic         expired
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign expired = (cnt_reg == '0);

endmodule

// File: rtl/ws2812_stream_driver.sv
// WS2812 frame driver: buffers one pixel ahead of a 24-bit shift register and
// emits NRZ bit cells, stretching the line low while waiting for late pixels.
module ws2812_stream_driver
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS     = 6,
    parameter int T0H_CYC      = 11,
    parameter int T0L_CYC      = 46,
    parameter int T1H_CYC      = 28,
    parameter int T1L_CYC      = 29,
    parameter int TRST_CYC     = 2400,
    parameter int UNDERRUN_CYC = 600
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PIXEL_BITS-1:0] pix_data,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic                  blank,
    output logic                  dout,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  underrun
);

    localparam int TMAX = max_int(max_int(max_int(T0H_CYC, T0L_CYC), max_int(T1H_CYC, T1L_CYC)),
                                  max_int(TRST_CYC, UNDERRUN_CYC));
    localparam int TW   = $clog2(TMAX) + 1;
    localparam int PW   = $clog2(NUM_LEDS) + 1;
    localparam int BW   = $clog2(PIXEL_BITS);

    ws_state_t               state_reg, state_next;
    logic                    hold_full_reg;
    logic [PIXEL_BITS-1:0]   hold_data_reg;
    logic [PIXEL_BITS-1:0]   shift_reg;
    logic [BW-1:0]           bit_cnt_reg;
    logic [PW-1:0]           pix_cnt_reg;
    logic                    frame_done_reg, frame_done_next;
    logic                    underrun_reg, underrun_next;

    logic                    drain;
    logic                    timer_load;
    logic [TW-1:0]           timer_val;
    logic                    expired;
    logic                    last_bit;
    logic                    last_pixel;
    logic                    tx_bit;

    assign last_bit   = (bit_cnt_reg == BW'(PIXEL_BITS - 1));
    assign last_pixel = (pix_cnt_reg == PW'(NUM_LEDS - 1));

    always_comb begin
        state_next      = state_reg;
        drain           = 1'b0;
        frame_done_next = 1'b0;
        underrun_next   = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = hold_full_reg ? ST_HIGH : ST_WAIT;
                    drain      = hold_full_reg;
                end
            end
            ST_WAIT: begin
                // A pixel that lands in the timeout cycle stays buffered for the next frame.
                if (hold_full_reg) begin
                    state_next = ST_HIGH;
                    drain      = 1'b1;
                end else if (expired) begin
                    state_next    = ST_LATCH;
                    underrun_next = 1'b1;
                end
            end
            ST_HIGH: begin
                if (expired) state_next = ST_LOW;
            end
            ST_LOW: begin
                if (expired) begin
                    if (!last_bit) begin
                        state_next = ST_HIGH;
                    end else if (last_pixel) begin
                        state_next = ST_LATCH;
                    end else if (hold_full_reg) begin
                        state_next = ST_HIGH;
                        drain      = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_LATCH: begin
                if (expired) begin
                    state_next      = ST_IDLE;
                    frame_done_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Every state change starts a fresh timed phase sized by the state being entered.
    always_comb begin
        timer_load = (state_next != state_reg);
        tx_bit     = drain ? hold_data_reg[GRB_FIRST_BIT] : shift_reg[GRB_FIRST_BIT-1];
        timer_val  = '0;
        unique case (state_next)
            ST_HIGH:  timer_val = tx_bit ? TW'(T1H_CYC - 1) : TW'(T0H_CYC - 1);
            ST_LOW:   timer_val = shift_reg[GRB_FIRST_BIT] ? TW'(T1L_CYC - 1) : TW'(T0L_CYC - 1);
            ST_WAIT:  timer_val = TW'(UNDERRUN_CYC - 1);
            ST_LATCH: timer_val = TW'(TRST_CYC - 1);
            default:  timer_val = '0;
        endcase
    end

    ws_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_val (timer_val),
        .load     (timer_load),
        .expired  (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            hold_full_reg  <= 1'b0;
            hold_data_reg  <= '0;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            pix_cnt_reg    <= '0;
            frame_done_reg <= 1'b0;
            underrun_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            frame_done_reg <= frame_done_next;
            underrun_reg   <= underrun_next;

            if (drain) begin
                hold_full_reg <= 1'b0;
            end else if (pix_valid && !hold_full_reg) begin
                hold_full_reg <= 1'b1;
                hold_data_reg <= pix_data;
            end

            if (drain) begin
                shift_reg   <= hold_data_reg;
                bit_cnt_reg <= '0;
            end else if (state_reg == ST_LOW && expired && !last_bit) begin
                shift_reg   <= {shift_reg[PIXEL_BITS-2:0], 1'b0};
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end

            if (state_reg == ST_LATCH && expired) begin
                pix_cnt_reg <= '0;
            end else if (state_reg == ST_LOW && expired && last_bit) begin
                pix_cnt_reg <= pix_cnt_reg + 1'b1;
            end
        end
    end

    assign pix_ready  = ~hold_full_reg;
    assign dout       = (state_reg == ST_HIGH) & ~blank;
    assign busy       = (state_reg != ST_IDLE);
    assign frame_done = frame_done_reg;
    assign underrun   = underrun_reg;

endmodule

// File: tb/tb_ws2812_stream_driver.sv
// Frame-level bench for ws2812_stream_driver: a pixel feeder, a waveform capture
// and a queue of expected pulse widths built from the pixels handed to the feeder.
module tb_ws2812_stream_driver;

    localparam int T0H = 11;
    localparam int T0L = 46;
    localparam int T1H = 28;
    localparam int T1L = 29;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        blank;
    logic        dout;
    logic        busy;
    logic        frame_done;
    logic        underrun;

    always #5 clk = ~clk;

    ws2812_stream_driver #(.NUM_LEDS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .blank      (blank),
        .dout       (dout),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] feed_q[$];
    int exp_high_q[$];
    int exp_low_q[$];
    int highs_q[$];
    int lows_q[$];
    int fd_cycle, ur_cycle, fd_count, ur_count, dout_high_cnt;
    bit xfer_pend;

    // Source side: holds each pixel valid until the handshake completes.
    initial begin
        logic [23:0] popped;
        pix_valid = 1'b0;
        pix_data  = '0;
        xfer_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (xfer_pend) begin
                popped    = feed_q.pop_front();
                pix_valid = 1'b0;
            end
            if (!pix_valid && feed_q.size() > 0) begin
                pix_data  = feed_q[0];
                pix_valid = 1'b1;
            end
            xfer_pend = pix_valid && pix_ready && !rst;
        end
    end

    task automatic push_pixel(input logic [23:0] px, input bit to_feed);
        if (to_feed) feed_q.push_back(px);
        for (int b = 23; b >= 0; b--) begin
            exp_high_q.push_back(px[b] ? T1H : T0H);
            exp_low_q.push_back(px[b] ? T1L : T0L);
        end
    endtask

    task automatic clear_expect();
        exp_high_q.delete();
        exp_low_q.delete();
    endtask

    // Records pulse widths and pulse times; cycle 1 is the first sample after start is taken.
    task automatic capture(input int n);
        int  run;
        bit  level;
        bit  seen_high;
        highs_q.delete();
        lows_q.delete();
        fd_cycle = -1; ur_cycle = -1; fd_count = 0; ur_count = 0; dout_high_cnt = 0;
        run = 0; level = 1'b0; seen_high = 1'b0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (dout === 1'b1) begin
                dout_high_cnt++;
                if (level) run++;
                else begin
                    if (seen_high) lows_q.push_back(run);
                    run = 1; level = 1'b1; seen_high = 1'b1;
                end
            end else begin
                if (level) begin
                    highs_q.push_back(run);
                    run = 1; level = 1'b0;
                end else run++;
            end
            if (frame_done === 1'b1) begin
                fd_count++;
                if (fd_cycle < 0) fd_cycle = c;
            end
            if (underrun === 1'b1) begin
                ur_count++;
                if (ur_cycle < 0) ur_cycle = c;
            end
        end
    endtask

    task automatic preload(input logic [23:0] p1, input logic [23:0] p2, input bit feed_p2);
        push_pixel(p1, 1'b1);
        for (int i = 0; i < 10 && pix_ready !== 1'b0; i++) @(negedge clk);
        n_checks++;
        if (pix_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL preload_accept: pix_ready=%b required 0", pix_ready);
        end
        push_pixel(p2, feed_p2);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; blank = 1'b0;
        repeat (3) @(negedge clk);
        n_checks += 5;
        if (dout !== 1'b0) begin n_fail++; $display("FAIL reset_dout: got %b required 0", dout); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL reset_pix_ready: got %b required 1", pix_ready); end
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
        if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b required 0", underrun); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        $display("reset: checked idle outputs");
    endtask

    task automatic test_basic_frame();
        int e, a;
        preload(24'hFF0000, 24'h000001, 1'b1);
        @(negedge clk); start = 1'b1;
        fork
            capture(5200);
            begin @(negedge clk); start = 1'b0; end
        join
        for (int i = 0; i < 48; i++) begin
            e = exp_high_q.pop_front();
            a = (highs_q.size() > 0) ? highs_q.pop_front() : -1;
            n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL basic_high[%0d]: got %0d required %0d", i, a, e); end
        end
        for (int i = 0; i < 47; i++) begin
            e = exp_low_q.pop_front();
            a = (lows_q.size() > 0) ? lows_q.pop_front() : -1;
            n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL basic_low[%0d]: got %0d required %0d", i, a, e); end
        end
        n_checks += 3;
        if (fd_cycle !== 5137) begin n_fail++; $display("FAIL basic_frame_done_cycle: got %0d required 5137", fd_cycle); end
        if (fd_count !== 1) begin n_fail++; $display("FAIL basic_frame_done_count: got %0d required 1", fd_count); end
        if (ur_count !== 0) begin n_fail++; $display("FAIL basic_underrun_count: got %0d required 0", ur_count); end
        clear_expect();
        $display("basic_frame: frame_done at cycle %0d", fd_cycle);
    endtask

    task automatic test_late_pixel();
        int e, a;
        preload(24'hFF0000, 24'h000001, 1'b0);
        @(negedge clk); start = 1'b1;
        fork
            capture(5400);
            begin
                @(negedge clk); start = 1'b0;
                repeat (1467) @(negedge clk);
                feed_q.push_back(24'h000001);
            end
        join
        for (int i = 0; i < 48; i++) begin
            e = exp_high_q.pop_front();
            a = (highs_q.size() > 0) ? highs_q.pop_front() : -1;
            n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL late_high[%0d]: got %0d required %0d", i, a, e); end
        end
        for (int i = 0; i < 47; i++) begin
            e = exp_low_q.pop_front();
            a = (lows_q.size() > 0) ? lows_q.pop_front() : -1;
            n_checks++;
            if (i == 23) begin
                if (a < e + 95 || a > e + 110) begin
                    n_fail++; $display("FAIL late_stretch: got %0d required %0d..%0d", a, e + 95, e + 110);
                end
            end else if (a !== e) begin
                n_fail++; $display("FAIL late_low[%0d]: got %0d required %0d", i, a, e);
            end
        end
        n_checks += 2;
        if (ur_count !== 0) begin n_fail++; $display("FAIL late_underrun_count: got %0d required 0", ur_count); end
        if (fd_count !== 1) begin n_fail++; $display("FAIL late_frame_done_count: got %0d required 1", fd_count); end
        clear_expect();
        $display("late_pixel: frame_done at cycle %0d", fd_cycle);
    endtask

    task automatic test_underrun();
        int e, a;
        push_pixel(24'hFF0000, 1'b1);
        for (int i = 0; i < 10 && pix_ready !== 1'b0; i++) @(negedge clk);
        @(negedge clk); start = 1'b1;
        fork
            capture(4500);
            begin @(negedge clk); start = 1'b0; end
        join
        for (int i = 0; i < 24; i++) begin
            e = exp_high_q.pop_front();
            a = (highs_q.size() > 0) ? highs_q.pop_front() : -1;
            n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL underrun_high[%0d]: got %0d required %0d", i, a, e); end
        end
        n_checks += 5;
        if (highs_q.size() !== 0) begin n_fail++; $display("FAIL underrun_extra_pulses: got %0d required 0", highs_q.size()); end
        if (ur_cycle !== 1969) begin n_fail++; $display("FAIL underrun_cycle: got %0d required 1969", ur_cycle); end
        if (ur_count !== 1) begin n_fail++; $display("FAIL underrun_count: got %0d required 1", ur_count); end
        if (fd_cycle !== 4369) begin n_fail++; $display("FAIL underrun_frame_done_cycle: got %0d required 4369", fd_cycle); end
        if (fd_count !== 1) begin n_fail++; $display("FAIL underrun_frame_done_count: got %0d required 1", fd_count); end
        clear_expect();
        $display("underrun: pulse at cycle %0d, frame_done at cycle %0d", ur_cycle, fd_cycle);
    endtask

    task automatic test_blank();
        preload(24'hFF0000, 24'h000001, 1'b1);
        blank = 1'b1;
        @(negedge clk); start = 1'b1;
        fork
            capture(5200);
            begin @(negedge clk); start = 1'b0; end
        join
        blank = 1'b0;
        n_checks += 3;
        if (dout_high_cnt !== 0) begin n_fail++; $display("FAIL blank_dout_high: got %0d required 0", dout_high_cnt); end
        if (fd_cycle !== 5137) begin n_fail++; $display("FAIL blank_frame_done_cycle: got %0d required 5137", fd_cycle); end
        if (fd_count !== 1) begin n_fail++; $display("FAIL blank_frame_done_count: got %0d required 1", fd_count); end
        clear_expect();
        $display("blank: frame_done at cycle %0d", fd_cycle);
    endtask

    task automatic test_abort();
        preload(24'hFF0000, 24'h000001, 1'b1);
        @(negedge clk); start = 1'b1;
        fork
            capture(5500);
            begin
                @(negedge clk); start = 1'b0;
                repeat (574) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                n_checks += 3;
                if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b required 0", busy); end
                if (dout !== 1'b0) begin n_fail++; $display("FAIL abort_dout: got %b required 0", dout); end
                if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL abort_pix_ready: got %b required 1", pix_ready); end
                rst = 1'b0;
            end
        join
        n_checks += 3;
        if (fd_count !== 0) begin n_fail++; $display("FAIL abort_frame_done_count: got %0d required 0", fd_count); end
        if (ur_count !== 0) begin n_fail++; $display("FAIL abort_underrun_count: got %0d required 0", ur_count); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_after: got %b required 0", busy); end
        clear_expect();
        $display("abort: reset mid-frame, %0d frame_done pulses", fd_count);
    endtask

    task automatic test_start_ignored();
        preload(24'hFF0000, 24'h000001, 1'b1);
        @(negedge clk); start = 1'b1;
        fork
            capture(8000);
            begin
                @(negedge clk); start = 1'b0;
                repeat (9) @(negedge clk);
                start = 1'b1; @(negedge clk); start = 1'b0;
                repeat (2989) @(negedge clk);
                start = 1'b1; @(negedge clk); start = 1'b0;
            end
        join
        n_checks += 4;
        if (fd_count !== 1) begin n_fail++; $display("FAIL ignore_frame_done_count: got %0d required 1", fd_count); end
        if (fd_cycle !== 5137) begin n_fail++; $display("FAIL ignore_frame_done_cycle: got %0d required 5137", fd_cycle); end
        if (highs_q.size() !== 48) begin n_fail++; $display("FAIL ignore_pulse_count: got %0d required 48", highs_q.size()); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_after: got %b required 0", busy); end
        clear_expect();
        $display("start_ignored: %0d frame_done pulses", fd_count);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_late_pixel();
        test_underrun();
        test_blank();
        test_abort();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
